// File: rtl/sum_acc_pkg.sv
// Shared widths and FSM encoding for the sum accumulator block.
package sum_acc_pkg;
    localparam int TOTAL_W = 16;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;
endpackage

// File: rtl/sum_accumulator_beat_counter.sv
// Counts accepted beats of a burst and flags the beat that completes it.
module beat_counter
    import sum_acc_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic last
);
    localparam logic [CNT_W-1:0] TC = CNT_W'(BURST_LEN - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // last is qualified by enable so it only fires on an actual transfer
    assign last = enable && (count == TC);
endmodule

// File: rtl/sum_accumulator.sv
// Accumulates {COUT,SUM} beats from an upstream 8-bit adder into a 16-bit burst total.
//   state | meaning
//   IDLE  | waiting for start; last result held on outputs
//   ACCUM | accepting beats until BURST_LEN have transferred
//   DONE  | result valid, held until out_ready
module sum_accumulator
    import sum_acc_pkg::*;
#(
    parameter int BURST_LEN = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         SUM,
    input  logic               COUT,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [TOTAL_W-1:0] total,
    output logic [CNT_W-1:0]   carry_cnt,
    output logic               ovf,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy
);
    state_t           state;
    logic             beat;
    logic             clear;
    logic             last;
    logic [TOTAL_W:0] sum_next;

    assign beat     = in_valid && in_ready;
    assign clear    = (state == IDLE) && start;
    assign sum_next = {1'b0, total} + (TOTAL_W + 1)'({COUT, SUM});

    beat_counter #(
        .BURST_LEN(BURST_LEN)
    ) u_beat_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .enable(beat),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            total     <= '0;
            carry_cnt <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= ACCUM;
                        total     <= '0;
                        carry_cnt <= '0;
                        ovf       <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        total <= sum_next[TOTAL_W-1:0];
                        ovf   <= ovf | sum_next[TOTAL_W];
                        if (COUT) begin
                            carry_cnt <= carry_cnt + CNT_W'(1);
                        end
                        if (last) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // start is deliberately not looked at here, even alongside out_ready
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end
endmodule
